// File: rtl/hc_gate_bank_if.sv
// Port bundle for hc_gate_bank: gate data, mode handshake and output enable.
// Counter signals exist only when HC_GATE_CNT_EN is defined.
interface hc_gate_bank_if #(
  parameter int unsigned CH    = 4,
  parameter int unsigned CNT_W = 8
);
  logic [CH-1:0] A;
  logic [CH-1:0] B;
  logic [2:0]    MODE;
  logic          MODE_VLD;
  logic          MODE_RDY;
  logic          MODE_ERR;
  logic          OE;
  logic [CH-1:0] Y;
`ifdef HC_GATE_CNT_EN
  logic                CNT_CLR;
  logic [CH*CNT_W-1:0] CNT;
`endif

  if (CH < 1 || CNT_W < 2) begin : g_param_check
    $error("hc_gate_bank_if: CH must be >= 1 and CNT_W >= 2");
  end

`ifdef HC_GATE_CNT_EN
  modport master (
    output A, B, MODE, MODE_VLD, OE, CNT_CLR,
    input  MODE_RDY, MODE_ERR, Y, CNT
  );
  modport slave (
    input  A, B, MODE, MODE_VLD, OE, CNT_CLR,
    output MODE_RDY, MODE_ERR, Y, CNT
  );
`else
  modport master (
    output A, B, MODE, MODE_VLD, OE,
    input  MODE_RDY, MODE_ERR, Y
  );
  modport slave (
    input  A, B, MODE, MODE_VLD, OE,
    output MODE_RDY, MODE_ERR, Y
  );
`endif
endinterface

// File: rtl/hc_gate_bank.sv
// Bank of CH registered 2-input gates sharing one run-time selectable function.
// Optional per-channel rising-edge counters are enabled with HC_GATE_CNT_EN.
module hc_gate_bank #(
  parameter int unsigned CH    = 4,
  parameter int unsigned CNT_W = 8
) (
  input logic           CLK,
  input logic           RST,
  hc_gate_bank_if.slave bus
);

  localparam logic [2:0] MODE_OR   = 3'd0;
  localparam logic [2:0] MODE_AND  = 3'd1;
  localparam logic [2:0] MODE_XOR  = 3'd2;
  localparam logic [2:0] MODE_NOR  = 3'd3;
  localparam logic [2:0] MODE_NAND = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;

  typedef enum logic {RUN, BLANK} state_t;

  if (CH < 1 || CNT_W < 2) begin : g_param_check
    $error("hc_gate_bank: CH must be >= 1 and CNT_W >= 2");
  end

  state_t        state_q, state_d;
  logic          blank_q, blank_d;
  logic [2:0]    pending_q, pending_d;
  logic [2:0]    active_q, active_d;
  logic          err_q, err_d;
  logic          y_clr;
  logic [CH-1:0] a_q, b_q, y_q;

  function automatic logic [CH-1:0] gate_f(input logic [2:0] m,
                                           input logic [CH-1:0] a,
                                           input logic [CH-1:0] b);
    case (m)
      MODE_OR:   return a | b;
      MODE_AND:  return a & b;
      MODE_XOR:  return a ^ b;
      MODE_NOR:  return ~(a | b);
      MODE_NAND: return ~(a & b);
      MODE_XNOR: return ~(a ^ b);
      default:   return '0;
    endcase
  endfunction

  // Mode handshake: valid codes start a two-edge blanking window, invalid codes only flag.
  always_comb begin
    state_d   = state_q;
    blank_d   = blank_q;
    pending_d = pending_q;
    active_d  = active_q;
    err_d     = 1'b0;
    y_clr     = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.MODE_VLD) begin
          if (bus.MODE <= MODE_XNOR) begin
            pending_d = bus.MODE;
            blank_d   = 1'b1;
            state_d   = BLANK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BLANK: begin
        y_clr = 1'b1;
        if (blank_q) begin
          blank_d = 1'b0;
        end else begin
          active_d = pending_q;
          state_d  = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= RUN;
      blank_q   <= 1'b0;
      pending_q <= MODE_OR;
      active_q  <= MODE_OR;
      err_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      blank_q   <= blank_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      err_q     <= err_d;
      a_q       <= bus.A;
      b_q       <= bus.B;
      y_q       <= y_clr ? '0 : gate_f(active_q, a_q, b_q);
    end
  end

  assign bus.MODE_RDY = (state_q == RUN);
  assign bus.MODE_ERR = err_q;
  assign bus.Y        = bus.OE ? y_q : '0;

`ifdef HC_GATE_CNT_EN
  logic [CH-1:0]       y_prev;
  logic [CH*CNT_W-1:0] cnt_q;

  // Saturating count of y_q rising edges, detected one edge after the rise; clear wins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      y_prev <= '0;
      cnt_q  <= '0;
    end else begin
      y_prev <= y_q;
      for (int i = 0; i < CH; i++) begin
        if (bus.CNT_CLR) begin
          cnt_q[i*CNT_W +: CNT_W] <= '0;
        end else if (y_q[i] && !y_prev[i] &&
                     (cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
          cnt_q[i*CNT_W +: CNT_W] <= cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.CNT = cnt_q;
`endif

endmodule

// File: doc/hc_gate_bank.md
# hc_gate_bank

Parametrised, registered successor to the quad 2-input OR gate: a bank of `CH` independent 2-input gates sharing one run-time-selectable logic function (OR/AND/XOR/NOR/NAND/XNOR). It sits between the board-level input pads and downstream logic. The function changes through a valid/ready handshake with a blanking sequence, so the bank can stand in for any member of the quad-gate family. Optional per-channel rising-edge counters support activity monitoring.

## Interface
Parameters:
- `CH`, 4, number of gate channels (≥1)
- `CNT_W`, 8, width of each per-channel transition counter (≥2)

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge
- `RST`  in  1  reset, synchronous, active-high
- `A`  in  `CH`  gate input A, one bit per channel
- `B`  in  `CH`  gate input B, one bit per channel
- `MODE`  in  3  requested function code
- `MODE_VLD`  in  1  `MODE` request valid
- `MODE_RDY`  out  1  block can accept a mode request
- `MODE_ERR`  out  1  one-cycle pulse: accepted request carried an invalid code
- `OE`  in  1  output enable
- `Y`  out  `CH`  gate outputs
- `CNT_CLR`  in  1  synchronous clear of all counters (`HC_GATE_CNT_EN` only)
- `CNT`  out  `CH*CNT_W`  channel i counter in bits [i*CNT_W +: CNT_W] (`HC_GATE_CNT_EN` only)

## Operation
- Mode codes:
  - 0 = OR (reset default)
  - 1 = AND
  - 2 = XOR
  - 3 = NOR
  - 4 = NAND
  - 5 = XNOR
  - 6 and 7 are invalid.
- Pipeline:
  - Stage 1 registers `A` and `B` into `a_q` and `b_q`.
  - Stage 2 registers `y_q[i] = f(active_mode, a_q[i], b_q[i])`.
- `Y = OE ? y_q : 0`. This is combinational gating only; `OE` does not affect internal state.
- FSM states:
  - RUN: `MODE_RDY=1`.
  - BLANK: `MODE_RDY=0`.
- Handshake:
  - A request is accepted on an edge where `MODE_VLD && MODE_RDY`.
  - `MODE_VLD` may stay high. After the return to RUN, the next accept occurs on the following edge with `MODE_VLD` high.
- Valid accepted code (0–5):
  - On the accept edge, `pending<=MODE`, state→BLANK, `blank_cnt<=1`.
  - On the next two edges, `y_q<=0`.
  - On the second of those edges, `active_mode<=pending` and state→RUN.
- Invalid accepted code (6–7):
  - On the accept edge, `MODE_ERR<=1` for exactly one cycle.
  - State stays RUN; `active_mode` and `y_q` are unaffected.
- Re-requesting the current mode still performs the full BLANK sequence.
- Counters (`HC_GATE_CNT_EN`):
  - `CNT[i]` increments on each edge where `y_q[i]` goes 0→1.
  - They saturate at 2^CNT_W−1.
  - `CNT_CLR` has priority over increment: if both occur on the same edge, the result is 0.
  - Counters see internal `y_q`, independent of `OE`.
- Reset values:
  - `a_q`, `b_q`, `y_q` = 0; hence `Y=0`.
  - `active_mode` = OR; `pending` = 0.
  - State = RUN, so `MODE_RDY=1`.
  - `MODE_ERR=0`; all `CNT=0`.
- `RST` during BLANK aborts the switch: the pending mode is discarded and the block returns to OR/RUN on the next cycle.

## Timing
- Data latency: a change on `A`/`B` sampled at edge n appears on `Y` after edge n+1, i.e. 2 cycles.
- Mode switch: accept at edge e0; `y_q=0` after e1 and e2; first new-function output after e3.
- `MODE_RDY` is low for exactly 2 cycles per valid accept.
- `OE` to `Y` is combinational, zero cycles.
- `MODE_ERR` is asserted in the cycle after the accept edge only.
- `CNT` reflects a rising `y_q` one cycle later (registered).

## Configuration
- `HC_GATE_CNT_EN` defined:
  - `CNT_CLR` input, `CNT` output and the counter logic are present.
- `HC_GATE_CNT_EN` undefined:
  - `CNT_CLR` and `CNT` ports are absent and no counter registers are synthesised.
  - All other behaviour is identical.

## Test plan
- Reset then default OR, `CH=4`:
  - Stimulus: `RST` 1 cycle; `A=4'b1010`, `B=4'b0110`.
  - Required: `Y=4'b1110` two cycles later; `MODE_RDY=1`.
- Mode switch to XOR:
  - Stimulus: `MODE=2` with `MODE_VLD` one cycle; `A=4'b1010`, `B=4'b0110` held.
  - Required: `MODE_RDY` low 2 cycles; `Y=0` for 2 cycles; then `Y=4'b1100`.
- Invalid code:
  - Stimulus: `MODE=7` accepted while in AND mode.
  - Required: `MODE_ERR` pulses once; `MODE_RDY` stays 1; `Y` keeps AND results with no blanking.
- Reset mid-switch:
  - Stimulus: request NAND, assert `RST` in the first BLANK cycle.
  - Required: `Y=0`; `A=B=4'b1111` then gives `Y=4'b1111` (OR, not NAND).
- OE gating:
  - Stimulus: `OE=0` with `y_q=4'b1111`.
  - Required: `Y=0` the same cycle; `OE=1` restores `4'b1111` with no pipeline delay.
- Counters (macro defined, `CNT_W=2`):
  - Stimulus: toggle `A[0]` in OR mode with `B=0` for 5 rising edges.
  - Required: `CNT[0]` saturates at 3.
  - Stimulus: `CNT_CLR` asserted on the same edge as a rising `y_q[0]`.
  - Required: `CNT[0]=0`.
